// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM encoding and the
// command-word layout pushed through the command FIFO.
package alu_pkg;

    localparam int OP_W   = 4;
    localparam int DATA_W = 4;
    localparam int RES_W  = 8;
    localparam int CMD_W  = OP_W + 2 * DATA_W;

    // bit3 selects the arithmetic group, bits[2:0] the operation within it
    typedef enum logic [OP_W-1:0] {
        OP_AND    = 4'b0000, OP_OR,  OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_NOT, OP_REDAND,
        OP_ADD    = 4'b1000, OP_SUB, OP_MUL, OP_DIV,  OP_MOD, OP_INC,  OP_SHR, OP_SHL
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD
    } seq_state_t;

    typedef struct packed {
        logic [OP_W-1:0]   sel;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    function automatic logic is_div_by_zero(input cmd_t c);
        return ((c.sel == OP_DIV) || (c.sel == OP_MOD)) && (c.b == '0);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU sequencer. Pushes are refused while full even if a pop
// happens on the same edge; the head word is readable combinationally.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  cmd_t                     din_i,
    input  logic                     pop_i,
    output cmd_t                     dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // The sequencer loads the head on the same edge it pops, so the read is unregistered.
    assign dout_o  = mem[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues queued commands to an external registered ALU and holds each result for the consumer.
// Define ALU_DIV_GUARD_EN to short-circuit divide/modulo by zero with res_data=8'hFF, res_err=1.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [3:0]             cmd_a,
    input  logic [3:0]             cmd_b,
    input  logic [3:0]             cmd_sel,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [3:0]             alu_sel,
    input  logic [7:0]             alu_y,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [7:0]             res_data,
    output logic                   res_err,
    output logic [$clog2(DEPTH):0] count
);

    seq_state_t  state_q;
    logic [3:0]  alu_a_q;
    logic [3:0]  alu_b_q;
    logic [3:0]  alu_sel_q;
    logic [7:0]  res_data_q;
    logic        res_valid_q;
    cmd_t        cmd_word;
    cmd_t        head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        guard_hit;

    assign cmd_word = {cmd_sel, cmd_a, cmd_b};

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_valid),
        .din_i   (cmd_word),
        .pop_i   (pop),
        .dout_o  (head),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign cmd_ready = !fifo_full;
    assign pop = !fifo_empty &&
                 ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && res_ready));

`ifdef ALU_DIV_GUARD_EN
    logic res_err_q;
    assign guard_hit = is_div_by_zero(head);
    assign res_err   = res_err_q;
`else
    assign guard_hit = 1'b0;
    assign res_err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
`ifdef ALU_DIV_GUARD_EN
            res_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_ISSUE: state_q <= ST_WAIT;
                ST_WAIT: begin
                    res_data_q  <= alu_y;
                    res_valid_q <= 1'b1;
                    state_q     <= ST_HOLD;
`ifdef ALU_DIV_GUARD_EN
                    res_err_q   <= 1'b0;
`endif
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: ;
            endcase
            // A pop (from IDLE or an accepted HOLD) overrides the transitions above.
            if (pop) begin
                if (guard_hit) begin
                    res_data_q  <= 8'hFF;
                    res_valid_q <= 1'b1;
                    state_q     <= ST_HOLD;
`ifdef ALU_DIV_GUARD_EN
                    res_err_q   <= 1'b1;
`endif
                end else begin
                    alu_a_q   <= head.a;
                    alu_b_q   <= head.b;
                    alu_sel_q <= head.sel;
                    state_q   <= ST_ISSUE;
                end
            end
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural registered ALU on the alu_* bus.
module tb_alu_cmd_sequencer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_a = '0;
    logic [3:0] cmd_b = '0;
    logic [3:0] cmd_sel = '0;
    logic [3:0] alu_a, alu_b, alu_sel;
    logic [7:0] alu_y = '0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic       res_err;
    logic [2:0] count;

    int n_checks = 0;
    int n_pass   = 0;

    alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_sel   (cmd_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_y     (alu_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] sel);
        logic [7:0] ae;
        logic [7:0] be;
        ae = {4'b0, a};
        be = {4'b0, b};
        case (sel)
            4'b0000: return ae & be;
            4'b0001: return ae | be;
            4'b0010: return ae ^ be;
            4'b0011: return {4'b0, ~(a & b)};
            4'b0100: return {4'b0, ~(a | b)};
            4'b0101: return {4'b0, ~(a ^ b)};
            4'b0110: return {4'b0, ~a};
            4'b0111: return {7'b0, &a};
            4'b1000: return ae + be;
            4'b1001: return ae - be;
            4'b1010: return ae * be;
            4'b1011: return (b == 4'd0) ? 8'hFF : ae / be;
            4'b1100: return (b == 4'd0) ? ae : ae % be;
            4'b1101: return ae + 8'd1;
            4'b1110: return ae >> b;
            default: return ae << b;
        endcase
    endfunction

    // External ALU: result registered one edge after it samples alu_*.
    always @(posedge clk) alu_y <= alu_model(alu_a, alu_b, alu_sel);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic push_cmd(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel);
        cmd_a     = a;
        cmd_b     = b;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
    endtask

    task automatic wait_result(input string tag, input logic [7:0] exp, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!res_valid && cycles < 10);
        check({tag, "_seen"}, res_valid, 1);
        check({tag, "_data"}, res_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] fa [6];
        logic [3:0] fb [6];
        logic [3:0] fs [6];
        int         f_cnt [6];
        logic       f_rdy [6];
        logic [7:0] f_res [5];
        logic [3:0] ra [8];
        logic [3:0] rb [8];
        logic [3:0] rs [8];
        logic [7:0] rexp [8];
        int         cyc;
        int         sent;
        int         got;
        int         last;
        logic       accepted;

        // ---------------- reset state
        tick();
        tick();
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_err", res_err, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_sel", alu_sel, 0);
        check("rst_count", count, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        rst = 1'b0;
        tick();

        // ---------------- single command: 3 + 5
        push_cmd(4'd3, 4'd5, 4'b1000);
        tick();
        cmd_valid = 1'b0;
        check("single_count_after_push", count, 1);
        check("single_alu_not_yet", alu_sel, 0);
        tick();
        check("single_alu_a", alu_a, 3);
        check("single_alu_b", alu_b, 5);
        check("single_alu_sel", alu_sel, 4'b1000);
        check("single_count_after_pop", count, 0);
        tick();
        check("single_not_valid_k2", res_valid, 0);
        tick();
        check("single_valid_k3", res_valid, 1);
        check("single_data", res_data, 8'h08);
        check("single_err", res_err, 0);
        res_ready = 1'b1;
        tick();
        check("single_released", res_valid, 0);
        res_ready = 1'b0;

        // ---------------- backpressure: 7-2 then 4*3, hold 10 cycles
        push_cmd(4'd7, 4'd2, 4'b1001);
        tick();
        push_cmd(4'd4, 4'd3, 4'b1010);
        tick();
        cmd_valid = 1'b0;
        check("bp_alu_sel_first", alu_sel, 4'b1001);
        check("bp_count", count, 1);
        tick();
        tick();
        check("bp_valid", res_valid, 1);
        check("bp_data", res_data, 8'h05);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", res_valid, 1);
            check("bp_hold_data", res_data, 8'h05);
            check("bp_hold_alu_sel", alu_sel, 4'b1001);
            check("bp_hold_count", count, 1);
        end
        res_ready = 1'b1;
        tick();
        check("bp_next_alu_sel", alu_sel, 4'b1010);
        check("bp_next_alu_a", alu_a, 4);
        check("bp_next_valid_low", res_valid, 0);
        check("bp_next_count", count, 0);
        tick();
        tick();
        check("bp_second_valid", res_valid, 1);
        check("bp_second_data", res_data, 8'h0C);
        tick();
        check("bp_idle", res_valid, 0);
        res_ready = 1'b0;

        // ---------------- fill: six pushes, the sixth refused
        fa = '{4'd1, 4'd2, 4'd15, 4'd6, 4'd9, 4'd8};
        fb = '{4'd1, 4'd3, 4'd15, 4'd3, 4'd4, 4'd8};
        fs = '{4'b1000, 4'b1000, 4'b1000, 4'b0010, 4'b1010, 4'b1000};
        f_cnt = '{1, 1, 2, 3, 4, 4};
        f_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        f_res = '{8'h02, 8'h05, 8'h1E, 8'h05, 8'h24};
        for (int i = 0; i < 6; i++) begin
            push_cmd(fa[i], fb[i], fs[i]);
            tick();
            check($sformatf("fill_count_%0d", i), count, f_cnt[i]);
            check($sformatf("fill_ready_%0d", i), cmd_ready, f_rdy[i]);
        end
        cmd_valid = 1'b0;
        check("fill_head_valid", res_valid, 1);
        check("fill_head_data", res_data, f_res[0]);
        res_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            wait_result($sformatf("fill_res_%0d", i), f_res[i], cyc);
            check($sformatf("fill_interval_%0d", i), cyc, 3);
        end
        tick();
        tick();
        tick();
        check("fill_drained_valid", res_valid, 0);
        check("fill_drained_count", count, 0);
        check("fill_last_alu_sel", alu_sel, 4'b1010);
        res_ready = 1'b0;

        // ---------------- divide by zero
        push_cmd(4'd9, 4'd0, 4'b1011);
        tick();
        cmd_valid = 1'b0;
        tick();
`ifdef ALU_DIV_GUARD_EN
        check("guard_valid", res_valid, 1);
        check("guard_data", res_data, 8'hFF);
        check("guard_err", res_err, 1);
        check("guard_alu_sel_kept", alu_sel, 4'b1010);
        check("guard_alu_b_kept", alu_b, 4);
`else
        check("noguard_alu_sel", alu_sel, 4'b1011);
        check("noguard_alu_b", alu_b, 0);
        check("noguard_not_valid", res_valid, 0);
        tick();
        tick();
        check("noguard_valid", res_valid, 1);
        check("noguard_data", res_data, 8'hFF);
        check("noguard_err", res_err, 0);
`endif
        res_ready = 1'b1;
        tick();
        check("guard_released", res_valid, 0);
        res_ready = 1'b0;

        // ---------------- async reset while in WAIT with two queued
        push_cmd(4'd5, 4'd5, 4'b0000);
        tick();
        push_cmd(4'd3, 4'd4, 4'b0001);
        tick();
        push_cmd(4'd2, 4'd2, 4'b1000);
        tick();
        cmd_valid = 1'b0;
        check("arst_pre_count", count, 2);
        check("arst_pre_alu_a", alu_a, 5);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", count, 0);
        check("arst_alu_a", alu_a, 0);
        check("arst_alu_b", alu_b, 0);
        check("arst_alu_sel", alu_sel, 0);
        check("arst_res_valid", res_valid, 0);
        check("arst_res_data", res_data, 0);
        check("arst_res_err", res_err, 0);
        check("arst_cmd_ready", cmd_ready, 1);
        tick();
        rst = 1'b0;
        push_cmd(4'd12, 4'd3, 4'b1001);
        tick();
        cmd_valid = 1'b0;
        wait_result("arst_post", 8'h09, cyc);
        check("arst_post_latency", cyc, 3);
        check("arst_post_err", res_err, 0);
        res_ready = 1'b1;
        tick();
        check("arst_post_count", count, 0);

        // ---------------- stream of 8 random commands, consumer always ready
        for (int i = 0; i < 8; i++) begin
            ra[i]   = 4'($urandom_range(0, 15));
            rb[i]   = 4'($urandom_range(1, 15));
            rs[i]   = 4'($urandom_range(0, 15));
            rexp[i] = alu_model(ra[i], rb[i], rs[i]);
        end
        sent = 0;
        got  = 0;
        last = -1;
        for (int c = 0; c < 80 && got < 8; c++) begin
            if (sent < 8) push_cmd(ra[sent], rb[sent], rs[sent]);
            else cmd_valid = 1'b0;
            accepted = cmd_valid && cmd_ready;
            tick();
            if (accepted) sent++;
            if (res_valid) begin
                check($sformatf("stream_data_%0d", got), res_data, rexp[got]);
                if (got > 0) check($sformatf("stream_interval_%0d", got), c - last, 3);
                last = c;
                got++;
            end
        end
        cmd_valid = 1'b0;
        check("stream_results", got, 8);
        check("stream_sent", sent, 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
